// File: rtl/sample_stream_tx_pkg.sv
// rtl/sample_stream_tx_pkg.sv - shared widths, mode encodings and helpers for sample_stream_tx
package sample_stream_tx_pkg;

  localparam int NB_DATA_DEF = 14;

  typedef enum logic {
    MODE_HOLD   = 1'b0,
    MODE_ZSTUFF = 1'b1
  } mode_e;

  // What the output stage does on a given cycle
  typedef enum logic [1:0] {
    ACT_IDLE      = 2'd0,
    ACT_LOAD      = 2'd1,
    ACT_INTERP    = 2'd2,
    ACT_UNDERFLOW = 2'd3
  } tick_act_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_stream_tx_sync_fifo.sv
// rtl/sample_stream_tx_sync_fifo.sv - single-clock FIFO with push/pop, full/empty and occupancy
module sync_fifo
  import sample_stream_tx_pkg::*;
#(
  parameter int WIDTH = NB_DATA_DEF,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [clog2(DEPTH):0]   o_level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  // Guarding here keeps the FIFO safe even if a caller ignores full/empty
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  assign o_full  = (count == FULL_LVL);
  assign o_empty = (count == '0);
  assign o_level = count;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_stream_tx.sv
// rtl/sample_stream_tx.sv - FIFO-buffered sample source with tick divider and hold/zero-stuff interpolation
module sample_stream_tx
  import sample_stream_tx_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int NB_DIV     = 8
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic [NB_DATA-1:0]            i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [NB_DIV-1:0]             i_div,
  input  logic [1:0]                    i_interp,
  input  logic                          i_mode,
  output logic [NB_DATA-1:0]            o_data,
  output logic                          o_en,
  output logic                          o_underflow,
  output logic [clog2(FIFO_DEPTH):0]    o_level
);

  logic [NB_DATA-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [NB_DIV-1:0]  div_cnt;
  logic               tick;
  logic [1:0]         phase;
  logic [1:0]         phase_eff;
  logic [1:0]         phase_nxt;
  logic [NB_DATA-1:0] hold_q;
  tick_act_e          act;
  mode_e              mode;

  assign push    = i_valid && !fifo_full;
  assign o_ready = !fifo_full;
  assign mode    = mode_e'(i_mode);

  sync_fifo #(
    .WIDTH (NB_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (i_data),
    .i_pop   (pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  // >= rather than == so a smaller i_div takes effect without wrapping
  assign tick = (div_cnt >= i_div);

  // A phase beyond the current factor restarts the cycle on this tick
  assign phase_eff = (phase > i_interp) ? 2'd0 : phase;

  always_comb begin
    act       = ACT_IDLE;
    phase_nxt = phase;
    if (tick) begin
      if (phase_eff != 2'd0) begin
        act = ACT_INTERP;
      end else if (fifo_empty) begin
        act = ACT_UNDERFLOW;
      end else begin
        act = ACT_LOAD;
      end
      if (act == ACT_UNDERFLOW || phase_eff == i_interp) begin
        phase_nxt = 2'd0;
      end else begin
        phase_nxt = phase_eff + 2'd1;
      end
    end
  end

  // Emptiness is the registered occupancy, so a same-cycle push cannot be popped
  assign pop = (act == ACT_LOAD);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt     <= '0;
      phase       <= 2'd0;
      hold_q      <= '0;
      o_data      <= '0;
      o_en        <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + NB_DIV'(1);
      phase       <= phase_nxt;
      o_en        <= 1'b0;
      o_underflow <= 1'b0;
      case (act)
        ACT_LOAD: begin
          hold_q <= fifo_head;
          o_data <= fifo_head;
          o_en   <= 1'b1;
        end
        ACT_INTERP: begin
          o_data <= (mode == MODE_ZSTUFF) ? '0 : hold_q;
          o_en   <= 1'b1;
        end
        ACT_UNDERFLOW: begin
          o_underflow <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_stream_tx.sv
// tb/tb_sample_stream_tx.sv - self-checking bench for sample_stream_tx
module tb_sample_stream_tx;

  localparam int NB_DATA    = 14;
  localparam int FIFO_DEPTH = 4;
  localparam int NB_DIV     = 8;
  localparam int NV         = 5;

  logic                clk = 1'b0;
  logic                i_rst_n;
  logic [NB_DATA-1:0]  i_data;
  logic                i_valid;
  logic                o_ready;
  logic [NB_DIV-1:0]   i_div;
  logic [1:0]          i_interp;
  logic                i_mode;
  logic [NB_DATA-1:0]  o_data;
  logic                o_en;
  logic                o_underflow;
  logic [2:0]          o_level;

  always #5 clk = ~clk;

  sample_stream_tx #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH),
    .NB_DIV     (NB_DIV)
  ) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_div       (i_div),
    .i_interp    (i_interp),
    .i_mode      (i_mode),
    .o_data      (o_data),
    .o_en        (o_en),
    .o_underflow (o_underflow),
    .o_level     (o_level)
  );

  typedef struct {
    int div;
    int interp;
    int mode;
    int n_in;
    int din[4];
    int n_out;
    int dout[8];
  } vec_t;

  vec_t vecs[NV];

  int total = 0;
  int bad   = 0;
  int sb[$];
  int cycle_no = 0;
  int last_en  = -1;
  int last_uf  = -1;
  int uf_cnt   = 0;
  int en_cnt   = 0;
  bit gap_chk  = 1'b0;
  int exp_gap  = 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge and scored here
  task automatic cyc();
    int e;
    @(posedge clk);
    #1;
    cycle_no++;
    if (o_en) begin
      en_cnt++;
      if (sb.size() == 0) begin
        chk("en_with_empty_scoreboard", int'(o_en), 0);
      end else begin
        e = sb.pop_front();
        chk("out_data", int'($signed(o_data)), e);
      end
      if (gap_chk && last_en >= 0) chk("en_gap", cycle_no - last_en, exp_gap);
      last_en = cycle_no;
    end
    if (o_underflow) begin
      uf_cnt++;
      last_uf = cycle_no;
      chk("underflow_with_en", int'(o_en), 0);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    gap_chk = 1'b0;
    cyc();
    cyc();
    i_rst_n = 1'b1;
    sb.delete();
    last_en = -1;
  endtask

  // Leaves i_valid asserted so back-to-back calls model a held valid
  task automatic push_sample(input int d);
    bit ok;
    ok = 1'b0;
    i_data  = NB_DATA'(d);
    i_valid = 1'b1;
    for (int k = 0; k < 2000 && !ok; k++) begin
      ok = o_ready;
      cyc();
    end
    if (!ok) chk("push_timeout", int'(o_ready), 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && sb.size() > 0; k++) cyc();
    chk("drain_remaining", sb.size(), 0);
  endtask

  task automatic wait_uf(input int target, input int budget);
    for (int k = 0; k < budget && uf_cnt < target; k++) cyc();
    chk("underflow_seen", uf_cnt >= target ? 1 : 0, 1);
  endtask

  initial begin
    int c0;
    int t1;
    int e0;

    vecs[0].div = 3; vecs[0].interp = 0; vecs[0].mode = 0;
    vecs[0].n_in = 3;  vecs[0].din  = '{5, -7, 100, 0};
    vecs[0].n_out = 3; vecs[0].dout = '{5, -7, 100, 0, 0, 0, 0, 0};
    vecs[1].div = 0; vecs[1].interp = 2; vecs[1].mode = 0;
    vecs[1].n_in = 2;  vecs[1].din  = '{10, 20, 0, 0};
    vecs[1].n_out = 6; vecs[1].dout = '{10, 10, 10, 20, 20, 20, 0, 0};
    vecs[2].div = 0; vecs[2].interp = 2; vecs[2].mode = 1;
    vecs[2].n_in = 2;  vecs[2].din  = '{10, 20, 0, 0};
    vecs[2].n_out = 6; vecs[2].dout = '{10, 0, 0, 20, 0, 0, 0, 0};
    vecs[3].div = 1; vecs[3].interp = 1; vecs[3].mode = 0;
    vecs[3].n_in = 2;  vecs[3].din  = '{-8192, 8191, 0, 0};
    vecs[3].n_out = 4; vecs[3].dout = '{-8192, -8192, 8191, 8191, 0, 0, 0, 0};
    vecs[4].div = 2; vecs[4].interp = 3; vecs[4].mode = 1;
    vecs[4].n_in = 1;  vecs[4].din  = '{-1, 0, 0, 0};
    vecs[4].n_out = 4; vecs[4].dout = '{-1, 0, 0, 0, 0, 0, 0, 0};

    i_rst_n  = 1'b0;
    i_data   = '0;
    i_valid  = 1'b0;
    i_div    = 8'd255;
    i_interp = 2'd0;
    i_mode   = 1'b0;

    // Reset state
    cyc();
    chk("ready_in_reset", int'(o_ready), 1);
    i_rst_n = 1'b1;
    cyc();
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_level", int'(o_level), 0);
    chk("rst_en", int'(o_en), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_underflow", int'(o_underflow), 0);

    // Table-driven streams
    for (int v = 0; v < NV; v++) begin
      do_reset();
      i_div    = 8'd255;
      i_interp = 2'(vecs[v].interp);
      i_mode   = vecs[v].mode[0];
      for (int k = 0; k < vecs[v].n_in; k++) push_sample(vecs[v].din[k]);
      i_valid = 1'b0;
      chk("preload_level", int'(o_level), vecs[v].n_in);
      for (int k = 0; k < vecs[v].n_out; k++) sb.push_back(vecs[v].dout[k]);
      gap_chk = 1'b1;
      exp_gap = vecs[v].div + 1;
      last_en = -1;
      i_div   = NB_DIV'(vecs[v].div);
      wait_drain(100);
      gap_chk = 1'b0;
      c0 = uf_cnt;
      wait_uf(c0 + 1, 50);
      t1 = last_uf;
      wait_uf(c0 + 2, 50);
      chk("underflow_period", last_uf - t1, vecs[v].div + 1);
    end

    // Backpressure: 6 samples with valid held, tick every 256 cycles
    do_reset();
    i_div    = 8'd255;
    i_interp = 2'd0;
    i_mode   = 1'b0;
    for (int k = 0; k < 6; k++) sb.push_back(11 + k);
    for (int k = 0; k < 4; k++) push_sample(11 + k);
    chk("full_level", int'(o_level), 4);
    chk("full_ready", int'(o_ready), 0);
    push_sample(15);
    chk("fifth_after_first_pop", sb.size(), 5);
    push_sample(16);
    chk("sixth_after_second_pop", sb.size(), 4);
    i_valid = 1'b0;
    wait_drain(2000);

    // Asynchronous reset with buffered samples
    do_reset();
    i_div = 8'd255;
    for (int k = 0; k < 3; k++) push_sample(50 + k);
    i_valid = 1'b0;
    chk("mid_level_before", int'(o_level), 3);
    i_rst_n = 1'b0;
    #1;
    chk("mid_level_async", int'(o_level), 0);
    chk("mid_ready_async", int'(o_ready), 1);
    cyc();
    i_rst_n = 1'b1;
    sb.delete();
    i_div = 8'd0;
    e0 = en_cnt;
    for (int k = 0; k < 10; k++) cyc();
    chk("mid_no_output", en_cnt - e0, 0);
    chk("mid_level_after", int'(o_level), 0);

    // Divider drop 200 -> 2 with counter at 50
    i_div = 8'd200;
    do_reset();
    c0 = uf_cnt;
    for (int k = 0; k < 50; k++) cyc();
    chk("div200_no_tick", uf_cnt - c0, 0);
    i_div = 8'd2;
    cyc();
    chk("div_drop_tick", int'(o_underflow), 1);
    cyc();
    chk("div_drop_gap1", int'(o_underflow), 0);
    cyc();
    chk("div_drop_gap2", int'(o_underflow), 0);
    cyc();
    chk("div_drop_period", int'(o_underflow), 1);

    // Push into empty FIFO on a tick cycle underflows, pops next tick
    do_reset();
    i_div = 8'd0;
    cyc();
    cyc();
    i_data  = NB_DATA'(77);
    i_valid = 1'b1;
    sb.push_back(77);
    e0 = en_cnt;
    cyc();
    i_valid = 1'b0;
    chk("push_on_tick_uf", int'(o_underflow), 1);
    chk("push_on_tick_no_en", en_cnt - e0, 0);
    cyc();
    chk("push_on_tick_next_en", en_cnt - e0, 1);
    chk("push_on_tick_sb", sb.size(), 0);

    // Shrinking L mid-cycle wraps the phase and pops immediately
    do_reset();
    i_div    = 8'd255;
    i_interp = 2'd3;
    i_mode   = 1'b0;
    push_sample(30);
    push_sample(40);
    i_valid = 1'b0;
    sb.push_back(30);
    sb.push_back(40);
    e0 = en_cnt;
    gap_chk = 1'b1;
    exp_gap = 1;
    last_en = -1;
    i_div   = 8'd0;
    for (int k = 0; k < 20 && en_cnt == e0; k++) cyc();
    i_interp = 2'd0;
    wait_drain(5);
    gap_chk = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("shrink_total_en", en_cnt - e0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
